// File: rtl/seq_divider_p.sv
// seq_divider_p: multi-cycle restoring divider, WIDTH-bit operands.
// One operand pair per Run; quotient/remainder after WIDTH+1 cycles.
// Optional signed mode is enabled by defining DIV_SIGNED_EN.
module seq_divider_p #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             Rst,
    input  logic             Run,
    input  logic             Signed,
    input  logic [WIDTH-1:0] Dvnd,
    input  logic [WIDTH-1:0] Dvsr,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             Rdy,
    output logic             Busy,
    output logic             DivZero
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t           state, next;
    logic [WIDTH-1:0] quo, rem, dvsr_w;
    logic [CW-1:0]    cnt;
    logic             accept, zero_dvsr, fits;
    logic [WIDTH-1:0] a_mag, b_mag, q_fix, r_fix;
    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] trial;

    assign accept    = Run && (state == IDLE || state == DONE);
    assign zero_dvsr = (Dvsr == '0);

    // Trial subtract carries an extra borrow bit beyond WIDTH+1 so the
    // shifted partial remainder never overflows the sign test.
    assign shifted = {rem, quo[WIDTH-1]};
    assign trial   = {1'b0, shifted} - {2'b00, dvsr_w};
    assign fits    = ~trial[WIDTH+1];

`ifdef DIV_SIGNED_EN
    logic q_neg, r_neg;

    assign a_mag = (Signed && Dvnd[WIDTH-1]) ? -Dvnd : Dvnd;
    assign b_mag = (Signed && Dvsr[WIDTH-1]) ? -Dvsr : Dvsr;
    assign q_fix = q_neg ? -quo : quo;
    assign r_fix = r_neg ? -rem : rem;

    // Result sign flags captured at accept
    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            q_neg <= 1'b0;
            r_neg <= 1'b0;
        end else if (accept && !zero_dvsr) begin
            q_neg <= Signed & (Dvnd[WIDTH-1] ^ Dvsr[WIDTH-1]);
            r_neg <= Signed & Dvnd[WIDTH-1];
        end
    end
`else
    logic signed_unused;

    assign signed_unused = Signed;
    assign a_mag = Dvnd;
    assign b_mag = Dvsr;
    assign q_fix = quo;
    assign r_fix = rem;
`endif

    // State register
    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) state <= IDLE;
        else     state <= next;
    end

    // Next-state logic
    always_comb begin
        next = state;
        case (state)
            IDLE, DONE: if (Run) next = zero_dvsr ? DONE : CALC;
            CALC:       if (cnt == LAST) next = FIX;
            FIX:        next = DONE;
            default:    next = IDLE;
        endcase
    end

    // Datapath, iteration counter and registered outputs
    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            quo     <= '0;
            rem     <= '0;
            dvsr_w  <= '0;
            cnt     <= '0;
            Q       <= '0;
            R       <= '0;
            Rdy     <= 1'b0;
            Busy    <= 1'b0;
            DivZero <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (Run) begin
                        if (zero_dvsr) begin
                            Q       <= '1;
                            R       <= Dvnd;
                            DivZero <= 1'b1;
                            Rdy     <= 1'b1;
                        end else begin
                            quo     <= a_mag;
                            rem     <= '0;
                            dvsr_w  <= b_mag;
                            cnt     <= '0;
                            Busy    <= 1'b1;
                            Rdy     <= 1'b0;
                            DivZero <= 1'b0;
                        end
                    end
                end
                CALC: begin
                    rem <= fits ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
                    quo <= {quo[WIDTH-2:0], fits};
                    cnt <= cnt + 1'b1;
                end
                FIX: begin
                    Q    <= q_fix;
                    R    <= r_fix;
                    Busy <= 1'b0;
                    Rdy  <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_divider_p.sv
// Testbench for seq_divider_p: WIDTH=32 and WIDTH=8 instances checked every
// cycle against a cycle-level arithmetic model, plus literal expectations.
module tb_seq_divider_p;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        Rst;
    logic        run0, sg0, rdy0, busy0, dz0;
    logic [31:0] a0, b0, q0, r0;
    logic        run1, sg1, rdy1, busy1, dz1;
    logic [7:0]  a1, b1, q1, r1;

    int n_tests = 0;
    int n_fail  = 0;

    seq_divider_p #(.WIDTH(32)) dut32 (
        .clk(clk), .Rst(Rst), .Run(run0), .Signed(sg0), .Dvnd(a0), .Dvsr(b0),
        .Q(q0), .R(r0), .Rdy(rdy0), .Busy(busy0), .DivZero(dz0)
    );
    seq_divider_p #(.WIDTH(8)) dut8 (
        .clk(clk), .Rst(Rst), .Run(run1), .Signed(sg1), .Dvnd(a1), .Dvsr(b1),
        .Q(q1), .R(r1), .Rdy(rdy1), .Busy(busy1), .DivZero(dz1)
    );

    function automatic int wid(int i);
        return (i == 0) ? 32 : 8;
    endfunction

    function automatic logic [63:0] mask(int w);
        return (64'd1 << w) - 64'd1;
    endfunction

    // Reference arithmetic: truncating division, remainder follows dividend
    function automatic void ref_div(int w, logic s, logic [63:0] a, logic [63:0] b,
                                    output logic [63:0] q, output logic [63:0] r);
        longint sa, sb;
        logic eff;
`ifdef DIV_SIGNED_EN
        eff = s;
`else
        eff = 1'b0;
`endif
        if (eff) begin
            sa = $signed(a << (64 - w)) >>> (64 - w);
            sb = $signed(b << (64 - w)) >>> (64 - w);
            q = 64'(sa / sb) & mask(w);
            r = 64'(sa % sb) & mask(w);
        end else begin
            q = (a / b) & mask(w);
            r = (a % b) & mask(w);
        end
    endfunction

    function automatic void get_in(int i, output logic run, output logic s,
                                   output logic [63:0] a, output logic [63:0] b);
        if (i == 0) begin run = run0; s = sg0; a = {32'd0, a0}; b = {32'd0, b0}; end
        else        begin run = run1; s = sg1; a = {56'd0, a1}; b = {56'd0, b1}; end
    endfunction

    function automatic void get_out(int i, output logic [63:0] q, output logic [63:0] r,
                                    output logic rdy, output logic busy, output logic dz);
        if (i == 0) begin q = {32'd0, q0}; r = {32'd0, r0}; rdy = rdy0; busy = busy0; dz = dz0; end
        else        begin q = {56'd0, q1}; r = {56'd0, r1}; rdy = rdy1; busy = busy1; dz = dz1; end
    endfunction

    task automatic set_in(int i, logic run, logic s, logic [63:0] a, logic [63:0] b);
        if (i == 0) begin run0 = run; sg0 = s; a0 = a[31:0]; b0 = b[31:0]; end
        else        begin run1 = run; sg1 = s; a1 = a[7:0];  b1 = b[7:0];  end
    endtask

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Cycle-level model: result appears WIDTH+1 edges after accept
    logic [63:0] m_q[2], m_r[2], p_q[2], p_r[2];
    logic        m_rdy[2], m_busy[2], m_dz[2];
    int          m_cnt[2];

    initial forever begin
        logic run, s;
        logic [63:0] a, b;
        @(posedge clk or posedge Rst);
        for (int i = 0; i < 2; i++) begin
            if (Rst) begin
                m_q[i] = '0; m_r[i] = '0; m_rdy[i] = 1'b0; m_busy[i] = 1'b0;
                m_dz[i] = 1'b0; m_cnt[i] = 0;
            end else if (!m_busy[i]) begin
                get_in(i, run, s, a, b);
                if (run) begin
                    if (b == 64'd0) begin
                        m_q[i] = mask(wid(i)); m_r[i] = a; m_dz[i] = 1'b1; m_rdy[i] = 1'b1;
                    end else begin
                        ref_div(wid(i), s, a, b, p_q[i], p_r[i]);
                        m_busy[i] = 1'b1; m_rdy[i] = 1'b0; m_dz[i] = 1'b0;
                        m_cnt[i] = wid(i) + 1;
                    end
                end
            end else begin
                m_cnt[i]--;
                if (m_cnt[i] == 0) begin
                    m_busy[i] = 1'b0; m_rdy[i] = 1'b1;
                    m_q[i] = p_q[i]; m_r[i] = p_r[i];
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    initial forever begin
        logic [63:0] q, r;
        logic rdy, busy, dz;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            get_out(i, q, r, rdy, busy, dz);
            check($sformatf("cyc%0d.Q", i), q, m_q[i]);
            check($sformatf("cyc%0d.R", i), r, m_r[i]);
            check($sformatf("cyc%0d.Rdy", i), {63'd0, rdy}, {63'd0, m_rdy[i]});
            check($sformatf("cyc%0d.Busy", i), {63'd0, busy}, {63'd0, m_busy[i]});
            check($sformatf("cyc%0d.DivZero", i), {63'd0, dz}, {63'd0, m_dz[i]});
        end
    end

    // Accept one operation and wait (bounded) for Rdy
    task automatic run_op(int i, logic s, logic [63:0] a, logic [63:0] b, bit hold, bit noise,
                          output int edges, output int busy_cnt);
        logic [63:0] q, r;
        logic rdy, busy, dz;
        set_in(i, 1'b1, s, a, b);
        @(posedge clk); #1;
        if (!hold) set_in(i, 1'b0, s, a, b);
        edges = 0; busy_cnt = 0;
        get_out(i, q, r, rdy, busy, dz);
        while (!rdy && edges < 100) begin
            if (busy) busy_cnt++;
            if (noise) set_in(i, 1'($urandom_range(1)), 1'($urandom_range(1)),
                              {$urandom, $urandom}, {$urandom, $urandom});
            @(posedge clk); #1;
            edges++;
            get_out(i, q, r, rdy, busy, dz);
        end
        if (edges >= 100) check("timeout", 64'(edges), 64'd99);
        set_in(i, 1'(hold), s, a, b);
    endtask

    task automatic check_out(string name, int i, logic [63:0] eq, logic [63:0] er,
                             logic erdy, logic ebusy, logic edz);
        logic [63:0] q, r;
        logic rdy, busy, dz;
        get_out(i, q, r, rdy, busy, dz);
        check({name, ".Q"}, q, eq);
        check({name, ".R"}, r, er);
        check({name, ".Rdy"}, {63'd0, rdy}, {63'd0, erdy});
        check({name, ".Busy"}, {63'd0, busy}, {63'd0, ebusy});
        check({name, ".DivZero"}, {63'd0, dz}, {63'd0, edz});
    endtask

    initial begin
        int edges, bcnt, i;
        logic [63:0] a, b;
        Rst = 1'b1;
        set_in(0, 1'b0, 1'b0, 64'd0, 64'd0);
        set_in(1, 1'b0, 1'b0, 64'd0, 64'd0);
        repeat (3) @(posedge clk);
        #1;
        check_out("reset", 0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0);
        Rst = 1'b0;
        @(posedge clk); #1;

        run_op(0, 1'b0, 64'd100, 64'd7, 0, 0, edges, bcnt);
        check("u100_7.latency", 64'(edges), 64'd33);
        check("u100_7.busy_cycles", 64'(bcnt), 64'd33);
        check_out("u100_7", 0, 64'd14, 64'd2, 1'b1, 1'b0, 1'b0);

        run_op(0, 1'b1, 64'hFFFF_FFF9, 64'd2, 0, 0, edges, bcnt);
`ifdef DIV_SIGNED_EN
        check_out("s_m7_2", 0, 64'hFFFF_FFFD, 64'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
`else
        check_out("s_m7_2", 0, 64'h7FFF_FFFC, 64'd1, 1'b1, 1'b0, 1'b0);
`endif

        run_op(0, 1'b0, 64'd5, 64'd0, 0, 0, edges, bcnt);
        check("divzero.latency", 64'(edges), 64'd0);
        check_out("divzero", 0, 64'hFFFF_FFFF, 64'd5, 1'b1, 1'b0, 1'b1);

        run_op(0, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 0, 0, edges, bcnt);
`ifdef DIV_SIGNED_EN
        check_out("ovf", 0, 64'h8000_0000, 64'd0, 1'b1, 1'b0, 1'b0);
`else
        check_out("ovf", 0, 64'd0, 64'h8000_0000, 1'b1, 1'b0, 1'b0);
`endif

        // Run held high throughout: ignored while busy, re-accepted in DONE
        run_op(0, 1'b0, 64'd20, 64'd6, 1, 0, edges, bcnt);
        check("hold.latency", 64'(edges), 64'd33);
        check_out("hold.done", 0, 64'd3, 64'd2, 1'b1, 1'b0, 1'b0);
        @(posedge clk); #1;
        check_out("hold.reaccept", 0, 64'd3, 64'd2, 1'b0, 1'b1, 1'b0);
        set_in(0, 1'b0, 1'b0, 64'd20, 64'd6);
        repeat (40) @(posedge clk);
        #1;
        check_out("hold.second", 0, 64'd3, 64'd2, 1'b1, 1'b0, 1'b0);

        // Reset in the middle of an operation
        set_in(0, 1'b1, 1'b0, 64'd1000, 64'd3);
        @(posedge clk); #1;
        set_in(0, 1'b0, 1'b0, 64'd1000, 64'd3);
        repeat (10) @(posedge clk);
        #1;
        Rst = 1'b1;
        #1;
        check_out("midreset", 0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        Rst = 1'b0;
        run_op(0, 1'b0, 64'd9, 64'd3, 0, 0, edges, bcnt);
        check_out("after_reset", 0, 64'd3, 64'd0, 1'b1, 1'b0, 1'b0);

        run_op(1, 1'b0, 64'd200, 64'd13, 0, 0, edges, bcnt);
        check("w8.latency", 64'(edges), 64'd9);
        check_out("w8", 1, 64'd15, 64'd5, 1'b1, 1'b0, 1'b0);

        // Randomized operations on both widths with noisy Run while busy
        for (int k = 0; k < 160; k++) begin
            i = k % 2;
            a = {$urandom, $urandom} & mask(wid(i));
            case ($urandom_range(7))
                0:       b = 64'd0;
                1:       b = 64'($urandom_range(15));
                2: begin a = 64'd1 << (wid(i) - 1); b = mask(wid(i)); end
                default: b = {$urandom, $urandom} & mask(wid(i));
            endcase
            run_op(i, 1'($urandom_range(1)), a, b, 0, 1, edges, bcnt);
            repeat ($urandom_range(2)) @(posedge clk);
            #1;
        end

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/seq_divider_p.md
# seq_divider_p

Parametrised multi-cycle restoring divider: the next generation of the fixed 32-bit unsigned divider. It adds a configurable width, an optional signed mode, divide-by-zero detection and a Busy/Rdy handshake. The block sits beside the datapath as a self-contained functional unit. It accepts one operand pair per `Run` and returns quotient and remainder after WIDTH+1 cycles.

## Interface
- `WIDTH`, default 32: operand and result width; legal range 4..64.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `Rst`  in  1: asynchronous reset, active-high.
- `Run`  in  1: start request; sampled only when not Busy.
- `Signed`  in  1: 1 = two's-complement divide, 0 = unsigned; sampled with `Run`.
- `Dvnd`  in  WIDTH: dividend; sampled with `Run`.
- `Dvsr`  in  WIDTH: divisor; sampled with `Run`.
- `Q`  out  WIDTH: quotient register.
- `R`  out  WIDTH: remainder register.
- `Rdy`  out  1: result valid; a level, not a pulse.
- `Busy`  out  1: operation in progress.
- `DivZero`  out  1: last accepted operation had `Dvsr == 0`.

## Operation
- States: IDLE, CALC, FIX, DONE. Reset state is IDLE.
- Accept condition: `Run=1` at a rising edge while in IDLE or DONE. That edge:
  - latches the operands and `Signed`;
  - clears `Rdy` and `DivZero`.
- Accept with `Dvsr == 0`:
  - next state DONE; Busy stays 0.
  - `Q` = all ones, `R` = `Dvnd` (raw bits), `DivZero=1`, `Rdy=1`.
- Accept with `Dvsr != 0`:
  - next state CALC; `Busy=1`; iteration counter cleared.
  - Working operands are magnitudes when signed mode is active, raw values otherwise.
  - Record quotient sign = sign(Dvnd) XOR sign(Dvsr); remainder sign = sign(Dvnd).
- CALC, one iteration per edge, WIDTH iterations:
  - shift the {rem, quo} pair left by 1;
  - trial subtract with WIDTH+1-bit arithmetic so there is no overflow at WIDTH bits;
  - if the result is non-negative, keep it and set quo bit 0 to 1; otherwise restore.
  - Counter width is $clog2(WIDTH+1). On the WIDTH-th iteration, next state is FIX.
- FIX, one edge:
  - negate quo if the quotient sign is set, and rem if the remainder sign is set (two's complement, WIDTH bits);
  - write `Q`/`R`; `Busy=0`, `Rdy=1`; next state DONE.
- Signed overflow, most-negative / -1: the result wraps to `Q` = most-negative, `R` = 0. No flag is raised.
- Remainder sign always follows the dividend; the quotient truncates toward zero.
- `Run` while Busy is ignored. No queueing.
- `Q`/`R` hold the previous result throughout CALC and FIX, and update only at FIX or at a zero-divisor accept.
- DONE holds `Rdy=1` indefinitely. If `Run` is asserted in DONE, the block accepts a new operation on that edge.

## Timing
- Reset values: `Q=0`, `R=0`, `Rdy=0`, `Busy=0`, `DivZero=0`, state IDLE, counter 0.
- Normal latency: take the accept edge as edge 0. CALC occupies edges 1..WIDTH, FIX is edge WIDTH+1, and `Rdy` is high after edge WIDTH+1. That is 33 cycles at WIDTH=32.
- Zero-divisor latency: `Rdy` and `DivZero` are high after the accept edge itself.
- `Busy` is high from after the accept edge until after the FIX edge.
- Asserting `Rst` mid-operation immediately forces all reset values. The in-flight result is discarded.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- `DIV_SIGNED_EN` defined:
  - the `Signed` input is honoured;
  - magnitude conversion and FIX-stage negation are synthesised.
- Not defined:
  - `Signed` is ignored and treated as 0; the block is unsigned only;
  - no sign logic is synthesised;
  - FIX still costs one cycle, so latency is unchanged.

## Test plan
- Reset mid-op: accept 1000/3, assert `Rst` at edge 10 → all outputs 0 immediately. The block then accepts 9/3 → `Q=3`, `R=0`.
- Unsigned, WIDTH=32: `Dvnd=100`, `Dvsr=7` → `Rdy` after edge 33 with `Q=14`, `R=2`; `Busy` high for exactly 33 cycles.
- Signed, with macro: `Dvnd=0xFFFFFFF9` (-7), `Dvsr=2` → `Q=0xFFFFFFFD`, `R=0xFFFFFFFF`. Without macro, same stimulus → `Q=0x7FFFFFFC`, `R=1`.
- Divide by zero: `Dvnd=5`, `Dvsr=0` → after 1 edge `Q=0xFFFFFFFF`, `R=5`, `DivZero=1`, `Rdy=1`, `Busy=0`.
- Signed overflow: `Dvnd=0x80000000`, `Dvsr=0xFFFFFFFF` → `Q=0x80000000`, `R=0`, `DivZero=0`.
- Handshake:
  - hold `Run=1` throughout 20/6 → `Run` is ignored while Busy, and `Q=3`, `R=2` stay stable;
  - the next edge in DONE re-accepts, dropping `Rdy`;
  - repeat the test at WIDTH=8 with 200/13 → `Q=15`, `R=5` after 9 edges.
